dcache_refill_engine: RTL

//  Responder end of the dCache miss-repair interface. Takes a read/write miss

---
 rtl/dcache_refill_engine.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/dcache_refill_engine.sv
// ---------------------------------------------------------------------------
// dcache_refill_engine
//
// Responder end of the dCache miss-repair interface. A read or write miss
// request from the dCache controller optionally writes back the dirty victim
// line as a burst of BEAT_BITS-wide beats. It then fetches the missed line
// from memory as a burst of BEATS beats in ascending order from offset 0. The
// assembled line is returned with a one-cycle repair_resolved pulse.
//
// Ports
//   clk, rst                 clock (rising edge), asynchronous active-low reset
//   read_miss_repair,
//   write_miss_repair        miss request levels (either or both = one request)
//   missed_addr              byte address of the missed line
//   evict_valid/addr/data    dirty victim to write back before the refill
//   repair_resolved          1-cycle pulse, refill_data valid
//   refill_data              assembled line, held until the next refill
//   busy                     engine not idle
//   err_stray_beat           sticky: read beat seen outside a read burst
//   mem_req_*                burst request (valid/ready, we, line address)
//   mem_w*                   write beat channel (valid/ready, data)
//   mem_rvalid, mem_rdata    read beat channel, no backpressure
// ---------------------------------------------------------------------------
module dcache_refill_engine #(
    parameter int LINE_BITS = 256,
    parameter int BEAT_BITS = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 read_miss_repair,
    input  logic                 write_miss_repair,
    input  logic [31:0]          missed_addr,
    input  logic                 evict_valid,
    input  logic [31:0]          evict_addr,
    input  logic [LINE_BITS-1:0] evict_data,
    output logic                 repair_resolved,
    output logic [LINE_BITS-1:0] refill_data,
    output logic                 busy,
    output logic                 err_stray_beat,
    output logic                 mem_req_valid,
    input  logic                 mem_req_ready,
    output logic                 mem_req_we,
    output logic [31:0]          mem_req_addr,
    output logic                 mem_wvalid,
    input  logic                 mem_wready,
    output logic [BEAT_BITS-1:0] mem_wdata,
    input  logic                 mem_rvalid,
    input  logic [BEAT_BITS-1:0] mem_rdata
);

    localparam int BEATS    = LINE_BITS / BEAT_BITS;
    localparam int CNT_W    = $clog2(BEATS);
    localparam int OFF_BITS = $clog2(LINE_BITS / 8);

    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);
    localparam logic [31:0]      LINE_MASK = ~((32'd1 << OFF_BITS) - 32'd1);

    typedef enum logic [2:0] {
        IDLE,
        WB_REQ,
        WB_DATA,
        RD_REQ,
        RD_DATA,
        RESOLVE,
        HOLDOFF
    } state_t;

    state_t                             state;
    logic [CNT_W-1:0]                   cnt;
    logic [31:0]                        miss_line;
    logic [BEATS-1:0][BEAT_BITS-1:0]    victim;
    logic [BEATS-1:0][BEAT_BITS-1:0]    refill_line;

    logic             req;
    logic [CNT_W-1:0] cnt_nx;

    assign req         = read_miss_repair | write_miss_repair;
    assign cnt_nx      = cnt + 1'b1;
    assign refill_data = refill_line;

    // All outputs are registered and loaded with the values for the state
    // being entered, so a reset clears them the instant it is asserted.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state           <= IDLE;
            cnt             <= '0;
            miss_line       <= '0;
            victim          <= '0;
            refill_line     <= '0;
            repair_resolved <= 1'b0;
            busy            <= 1'b0;
            err_stray_beat  <= 1'b0;
            mem_req_valid   <= 1'b0;
            mem_req_we      <= 1'b0;
            mem_req_addr    <= '0;
            mem_wvalid      <= 1'b0;
            mem_wdata       <= '0;
        end else begin
            if (mem_rvalid && state != RD_DATA)
                err_stray_beat <= 1'b1;

            case (state)
                IDLE: begin
                    if (req) begin
                        miss_line     <= missed_addr & LINE_MASK;
                        busy          <= 1'b1;
                        mem_req_valid <= 1'b1;
                        if (evict_valid) begin
                            victim       <= evict_data;
                            mem_req_we   <= 1'b1;
                            mem_req_addr <= evict_addr & LINE_MASK;
                            state        <= WB_REQ;
                        end else begin
                            mem_req_we   <= 1'b0;
                            mem_req_addr <= missed_addr & LINE_MASK;
                            state        <= RD_REQ;
                        end
                    end
                end

                WB_REQ: begin
                    if (mem_req_ready) begin
                        mem_req_valid <= 1'b0;
                        mem_wvalid    <= 1'b1;
                        mem_wdata     <= victim[0];
                        cnt           <= '0;
                        state         <= WB_DATA;
                    end
                end

                // mem_wdata is preloaded with the next word as each beat is
                // accepted, so the beat on the bus always matches cnt.
                WB_DATA: begin
                    if (mem_wready) begin
                        if (cnt == LAST_BEAT) begin
                            mem_wvalid    <= 1'b0;
                            mem_wdata     <= '0;
                            mem_req_valid <= 1'b1;
                            mem_req_we    <= 1'b0;
                            mem_req_addr  <= miss_line;
                            cnt           <= '0;
                            state         <= RD_REQ;
                        end else begin
                            cnt       <= cnt_nx;
                            mem_wdata <= victim[cnt_nx];
                        end
                    end
                end

                RD_REQ: begin
                    if (mem_req_ready) begin
                        mem_req_valid <= 1'b0;
                        cnt           <= '0;
                        state         <= RD_DATA;
                    end
                end

                RD_DATA: begin
                    if (mem_rvalid) begin
                        refill_line[cnt] <= mem_rdata;
                        if (cnt == LAST_BEAT) begin
                            cnt             <= '0;
                            repair_resolved <= 1'b1;
                            state           <= RESOLVE;
                        end else begin
                            cnt <= cnt_nx;
                        end
                    end
                end

                RESOLVE: begin
                    repair_resolved <= 1'b0;
                    state           <= HOLDOFF;
                end

                // The dCache still shows its miss level in this cycle; it is
                // ignored so the same miss is not repaired twice.
                HOLDOFF: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
